// File: rtl/hwpe_ctrl_job_queue.sv
// rtl/hwpe_ctrl_job_queue.sv - HWPE job queue: lock/acquire, job FIFO, dispatcher and status registers
//
// Purpose:
//   Cores acquire a lock (ACQUIRE read), commit a job (TRIGGER write), and the
//   job is queued with a monotonically increasing ID. A dispatcher hands jobs to
//   the engine one at a time and pulses a completion event to the offloading core.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_req_i..cfg_id_i   peripheral request (wen: 1 = read, 0 = write; id one-hot)
//   cfg_gnt_o..cfg_r_id_o peripheral response, registered (1-cycle latency)
//   done_i                engine finished the running job
//   start_o, busy_o       one-cycle start pulse / job in START or RUN
//   job_id_o              head job ID while busy
//   evt_o                 one-cycle completion pulse to the offloading core
//   clear_o               soft clear pulse
//
// Register map (word index): 0 TRIGGER(w), 1 ACQUIRE(r), 2 FINISHED(r),
//   3 STATUS(r), 4 RUNNING(r), 5 SOFT_CLEAR(w); others read 0.
//
// Option: define HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN to auto-release a lock held for
//   TIMEOUT_CYCLES cycles without a valid TRIGGER (STATUS bit 3 = timeout sticky).

module hwpe_ctrl_job_queue #(
    parameter int N_CORES        = 4,
    parameter int N_CONTEXT      = 3,
    parameter int JOB_ID_WIDTH   = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_req_i,
    input  logic                    cfg_wen_i,
    input  logic [ADDR_WIDTH-1:0]   cfg_add_i,
    input  logic [DATA_WIDTH-1:0]   cfg_data_i,
    input  logic [N_CORES-1:0]      cfg_id_i,
    output logic                    cfg_gnt_o,
    output logic [DATA_WIDTH-1:0]   cfg_r_data_o,
    output logic                    cfg_r_valid_o,
    output logic [N_CORES-1:0]      cfg_r_id_o,
    input  logic                    done_i,
    output logic                    start_o,
    output logic                    busy_o,
    output logic [JOB_ID_WIDTH-1:0] job_id_o,
    output logic [N_CORES-1:0]      evt_o,
    output logic                    clear_o
);

    localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int PTR_W  = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
    localparam int CNT_W  = $clog2(N_CONTEXT + 1);
    localparam int REG_W  = ADDR_WIDTH - 2;

    localparam logic [REG_W-1:0] R_TRIGGER  = REG_W'(0);
    localparam logic [REG_W-1:0] R_ACQUIRE  = REG_W'(1);
    localparam logic [REG_W-1:0] R_FINISHED = REG_W'(2);
    localparam logic [REG_W-1:0] R_STATUS   = REG_W'(3);
    localparam logic [REG_W-1:0] R_RUNNING  = REG_W'(4);
    localparam logic [REG_W-1:0] R_CLEAR    = REG_W'(5);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [JOB_ID_WIDTH-1:0] fifo_id_q   [N_CONTEXT];
    logic [JOB_ID_WIDTH-1:0] fifo_id_d   [N_CONTEXT];
    logic [CORE_W-1:0]       fifo_core_q [N_CONTEXT];
    logic [CORE_W-1:0]       fifo_core_d [N_CONTEXT];
    logic [JOB_ID_WIDTH-1:0] next_id_q, next_id_d;
    logic                    lock_q, lock_d;
    logic [N_CORES-1:0]      owner_q, owner_d;
    logic                    trig_err_q, trig_err_d;
    logic [DATA_WIDTH-1:0]   finished_q, finished_d;
    logic [N_CORES-1:0]      evt_q, evt_d;
    logic                    clear_q, clear_d;
    logic                    r_valid_q, r_valid_d;
    logic [N_CORES-1:0]      r_id_q, r_id_d;
    logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;

`ifdef HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    tmo_err_q, tmo_err_d;
    logic                    tmo_flag;
    assign tmo_flag = tmo_err_q;
`else
    logic                    tmo_flag;
    assign tmo_flag = 1'b0;
`endif

    logic [REG_W-1:0]        reg_idx;
    logic                    rd_req, wr_req;
    logic                    acq_free, acq_ok, trig_ok, trig_bad, soft_clr;
    logic                    push, pop;
    logic [CORE_W-1:0]       owner_idx;
    logic [JOB_ID_WIDTH-1:0] head_id;
    logic [CORE_W-1:0]       head_core;
    logic [JOB_ID_WIDTH-1:0] running_id;
    logic [31:0]             status_w;
    logic                    unused_bits;

    assign unused_bits = ^{cfg_data_i, cfg_add_i[1:0], (TIMEOUT_CYCLES > 0)};

    assign reg_idx  = cfg_add_i[ADDR_WIDTH-1:2];
    assign rd_req   = cfg_req_i & cfg_wen_i;
    assign wr_req   = cfg_req_i & ~cfg_wen_i;
    assign acq_free = !lock_q && (count_q < CNT_W'(N_CONTEXT));
    assign acq_ok   = rd_req && (reg_idx == R_ACQUIRE) && acq_free;
    assign trig_ok  = wr_req && (reg_idx == R_TRIGGER) && lock_q && (cfg_id_i == owner_q);
    assign trig_bad = wr_req && (reg_idx == R_TRIGGER) && !trig_ok;
    assign soft_clr = wr_req && (reg_idx == R_CLEAR);
    assign push     = trig_ok;
    assign pop      = (state_q == S_RUN) && done_i;

    assign head_id    = fifo_id_q[rd_ptr_q];
    assign head_core  = fifo_core_q[rd_ptr_q];
    assign running_id = (state_q != S_IDLE) ? head_id : '0;

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (owner_q[i]) owner_idx = CORE_W'(i);
        end
    end

    always_comb begin
        status_w        = '0;
        status_w[31:16] = 16'(count_q);
        status_w[3]     = tmo_flag;
        status_w[2]     = lock_q;
        status_w[1]     = trig_err_q;
        status_w[0]     = (state_q != S_IDLE);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_id_d   = fifo_id_q;
        fifo_core_d = fifo_core_q;
        next_id_d   = next_id_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        trig_err_d  = trig_err_q;
        finished_d  = finished_q;
        evt_d       = '0;
        clear_d     = soft_clr;
        r_valid_d   = cfg_req_i;
        r_id_d      = cfg_id_i;
        r_data_d    = '0;
`ifdef HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
`endif

        unique case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (done_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_id_d[wr_ptr_q]   = next_id_q;
            fifo_core_d[wr_ptr_q] = owner_idx;
            wr_ptr_d  = (wr_ptr_q == PTR_W'(N_CONTEXT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            next_id_d = next_id_q + JOB_ID_WIDTH'(1);
            lock_d    = 1'b0;
        end

        if (pop) begin
            rd_ptr_d   = (rd_ptr_q == PTR_W'(N_CONTEXT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            finished_d = finished_q + DATA_WIDTH'(1);
            evt_d      = N_CORES'(1) << head_core;
        end

        // Simultaneous push and pop leave the count unchanged.
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (acq_ok) begin
            lock_d  = 1'b1;
            owner_d = cfg_id_i;
        end

        if (trig_bad) trig_err_d = 1'b1;

`ifdef HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN
        // acq_ok only fires with the lock free, so it never overlaps the hold count.
        if (acq_ok) begin
            tmo_cnt_d = '0;
        end else if (lock_q && !push) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                lock_d    = 1'b0;
                tmo_err_d = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        if (rd_req) begin
            case (reg_idx)
                R_ACQUIRE:  r_data_d = acq_free ? DATA_WIDTH'(next_id_q) : '1;
                R_FINISHED: r_data_d = finished_q;
                R_STATUS:   r_data_d = DATA_WIDTH'(status_w);
                R_RUNNING:  r_data_d = DATA_WIDTH'(running_id);
                default:    r_data_d = '0;
            endcase
        end

        // Soft clear wins over everything else in the same cycle, including a
        // completion being recorded, so no event escapes a cleared queue.
        if (soft_clr) begin
            state_d    = S_IDLE;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            next_id_d  = '0;
            lock_d     = 1'b0;
            owner_d    = '0;
            trig_err_d = 1'b0;
            finished_d = '0;
            evt_d      = '0;
`ifdef HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN
            tmo_cnt_d  = '0;
            tmo_err_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < N_CONTEXT; i++) begin
                fifo_id_q[i]   <= '0;
                fifo_core_q[i] <= '0;
            end
            next_id_q  <= '0;
            lock_q     <= 1'b0;
            owner_q    <= '0;
            trig_err_q <= 1'b0;
            finished_q <= '0;
            evt_q      <= '0;
            clear_q    <= 1'b0;
            r_valid_q  <= 1'b0;
            r_id_q     <= '0;
            r_data_q   <= '0;
`ifdef HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_id_q   <= fifo_id_d;
            fifo_core_q <= fifo_core_d;
            next_id_q   <= next_id_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            trig_err_q  <= trig_err_d;
            finished_q  <= finished_d;
            evt_q       <= evt_d;
            clear_q     <= clear_d;
            r_valid_q   <= r_valid_d;
            r_id_q      <= r_id_d;
            r_data_q    <= r_data_d;
`ifdef HWPE_CTRL_JOB_QUEUE_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

    assign cfg_gnt_o     = 1'b1;
    assign cfg_r_data_o  = r_data_q;
    assign cfg_r_valid_o = r_valid_q;
    assign cfg_r_id_o    = r_id_q;
    assign start_o       = (state_q == S_START);
    assign busy_o        = (state_q != S_IDLE);
    assign job_id_o      = running_id;
    assign evt_o         = evt_q;
    assign clear_o       = clear_q;

endmodule
